// File: rtl/rr_stream_arbiter_4_pkg.sv
// Shared constants for the 4-source round-robin stream arbiter.
//   NUM_SRC : number of arbitrated sources
//   IDX_W   : width of a source index / round-robin pointer
//   DEF_W   : default payload width
package rr_stream_arbiter_4_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned DEF_W   = 4;

endpackage

// File: rtl/rr_stream_arbiter_4_pick.sv
// Combinational round-robin picker: first requesting index starting at ptr.
//   req   : per-source request vector
//   ptr   : highest-priority index this cycle
//   any   : at least one request present
//   index : chosen source (equals ptr when nothing requests)
module rr_pick_4
  import rr_stream_arbiter_4_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   index
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk ptr, ptr+1, ... modulo 4; the first hit wins.
  always_comb begin
    any   = |req;
    index = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        index = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_stream_arbiter_4.sv
// Four-source round-robin stream arbiter with a single output register.
//   clk, rst         : clock, synchronous active-high reset
//   in_valid         : per-source valid
//   in_data0..3      : per-source payloads
//   in_ready         : per-source accept strobe (combinational)
//   out_valid        : output register holds a word
//   out_data         : registered payload of the granted source
//   out_sel          : registered index of the source that supplied out_data
//   out_ready        : downstream accept
module rr_stream_arbiter_4
  import rr_stream_arbiter_4_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] in_valid,
  input  logic [W-1:0]       in_data0,
  input  logic [W-1:0]       in_data1,
  input  logic [W-1:0]       in_data2,
  input  logic [W-1:0]       in_data3,
  output logic [NUM_SRC-1:0] in_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic [IDX_W-1:0]   out_sel,
  input  logic               out_ready
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant;
  logic             any;
  logic             load;
  logic [W-1:0]     grant_data;

  rr_pick_4 u_pick (
    .req   (in_valid),
    .ptr   (ptr),
    .any   (any),
    .index (grant)
  );

  // Output register may be written when empty or being drained this cycle.
  assign load = !out_valid || out_ready;

  // Accept strobe; suppressed during reset so no word is lost into a reset edge.
  always_comb begin
    in_ready = '0;
    if (!rst && load && any) begin
      in_ready[grant] = 1'b1;
    end
  end

  // Payload select ahead of the output register.
  always_comb begin
    grant_data = in_data0;
    case (grant)
      2'd0:    grant_data = in_data0;
      2'd1:    grant_data = in_data1;
      2'd2:    grant_data = in_data2;
      2'd3:    grant_data = in_data3;
      default: grant_data = in_data0;
    endcase
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (any) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant;
        ptr       <= grant + IDX_W'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_arbiter_4.sv
// Self-checking bench for rr_stream_arbiter_4: directed scenarios plus random
// traffic, checked against a behavioural model and a word scoreboard.
module tb_rr_stream_arbiter_4;

  logic       clk;
  logic       rst;
  logic [3:0] in_valid;
  logic [3:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_sel;
  logic       out_ready;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int         m_ptr   = 0;
  logic       m_valid = 1'b0;
  logic [3:0] m_data  = '0;
  int         m_sel   = 0;
  logic [3:0] sb_q[$];

  rr_stream_arbiter_4 #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] src_data(input int i);
    case (i)
      0: return in_data0;
      1: return in_data1;
      2: return in_data2;
      default: return in_data3;
    endcase
  endfunction

  // One clock: check in_ready mid-cycle, advance model, check outputs after edge.
  task automatic cycle();
    logic [3:0] exp_rdy;
    int         g;
    logic       load;
    int         n_ptr;
    logic       n_valid;
    logic [3:0] n_data;
    int         n_sel;
    logic [3:0] front;
    @(negedge clk);
    exp_rdy = 4'b0;
    g = -1;
    load = !m_valid || out_ready;
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && in_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    end
    n_ptr = m_ptr; n_valid = m_valid; n_data = m_data; n_sel = m_sel;
    if (rst) begin
      n_ptr = 0; n_valid = 1'b0; n_data = '0; n_sel = 0;
    end else if (load) begin
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        n_valid = 1'b1;
        n_data  = src_data(g);
        n_sel   = g;
        n_ptr   = (g + 1) % 4;
      end else begin
        n_valid = 1'b0;
      end
    end
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (!rst && m_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        front = sb_q.pop_front();
        chk("sb_word", 32'(out_data), 32'(front));
      end
    end
    if (rst) sb_q.delete();
    else if (g >= 0 && load) sb_q.push_back(src_data(g));
    @(posedge clk);
    #1;
    m_ptr = n_ptr; m_valid = n_valid; m_data = n_data; m_sel = n_sel;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_sel", 32'(out_sel), 32'(m_sel));
    chk("out_data", 32'(out_data), 32'(m_data));
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'hF; out_ready = 1'b0;
    in_data0 = 4'ha; in_data1 = 4'hb; in_data2 = 4'hc; in_data3 = 4'hd;

    // Reset with all sources requesting
    cycle(); cycle();
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_od", 32'(out_data), 32'd0);
    chk("rst_os", 32'(out_sel), 32'd0);

    // Fairness: 0,1,2,3,0,1,2,3
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("fair_sel", 32'(out_sel), 32'(i % 4));
      chk("fair_data", 32'(out_data), 32'(4'ha + 4'(i % 4)));
      chk("fair_ov", 32'(out_valid), 32'd1);
    end

    // Skip: reset, grant 0, then 1010 -> 1,3,1
    rst = 1'b1; cycle(); rst = 1'b0;
    in_valid = 4'b0001; cycle();
    chk("skip_sel0", 32'(out_sel), 32'd0);
    in_valid = 4'b1010;
    cycle(); chk("skip_sel1", 32'(out_sel), 32'd1);
    cycle(); chk("skip_sel3", 32'(out_sel), 32'd3);
    cycle(); chk("skip_wrap", 32'(out_sel), 32'd1);

    // Backpressure with word from source 2 held
    in_valid = 4'hF; cycle();
    chk("bp_sel", 32'(out_sel), 32'd2);
    chk("bp_data", 32'(out_data), 32'hc);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold_rdy", 32'(in_ready), 32'd0);
      chk("bp_hold_data", 32'(out_data), 32'hc);
      chk("bp_hold_sel", 32'(out_sel), 32'd2);
    end
    out_ready = 1'b1; cycle();
    chk("bp_next", 32'(out_sel), 32'd3);

    // Idle after a word from source 1
    in_valid = 4'b0010; cycle();
    chk("idle_pre", 32'(out_sel), 32'd1);
    in_valid = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("idle_ov", 32'(out_valid), 32'd0);
      chk("idle_sel", 32'(out_sel), 32'd1);
    end
    in_valid = 4'b0001; cycle();
    chk("idle_resume_sel", 32'(out_sel), 32'd0);
    chk("idle_resume_ov", 32'(out_valid), 32'd1);

    // Mid-operation reset discards the held word
    in_valid = 4'hF; out_ready = 1'b0; cycle();
    chk("mid_held", 32'(out_valid), 32'd1);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("mid_ov", 32'(out_valid), 32'd0);
    out_ready = 1'b1; cycle();
    chk("mid_first", 32'(out_sel), 32'd0);

    // Random traffic against the model and scoreboard
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom);
      in_data0  = 4'($urandom); in_data1 = 4'($urandom);
      in_data2  = 4'($urandom); in_data3 = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0;
    chk("sb_level", 32'(sb_q.size()), 32'(m_valid));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_stream_arbiter_4.md
RR_STREAM_ARBITER_4 -- requirements
Module: rr_stream_arbiter_4

Interface
REQ-001 The module SHALL have parameter W, default 4, giving the data width of every stream.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  4  per-source valid; bit i belongs to source i.
REQ-005 in_data0, in_data1, in_data2, in_data3  input  W each  source payloads.
REQ-006 in_ready  output  4  per-source accept strobe; bit i high means source i's word is taken this cycle.
REQ-007 out_valid  output  1  output register holds a word.
REQ-008 out_data  output  W  registered payload of the granted source.
REQ-009 out_sel  output  2  registered index of the source that supplied out_data; this is the select for the downstream 4:1 mux.
REQ-010 out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high.

Function
REQ-011 Define load = !out_valid || out_ready; the output register is written only when load is 1.
REQ-012 Round-robin pointer ptr (2 bits) SHALL give priority order ptr, ptr+1, ptr+2, ptr+3 (mod 4); the grant g is the first index in that order with in_valid[g]=1.
REQ-013 in_ready[i] SHALL equal load && (in_valid has any bit set) && (g == i); at most one bit of in_ready is high per cycle.
REQ-014 in_ready SHALL be combinational from in_valid, out_valid, out_ready and ptr; no source SHALL be granted without its in_valid high.
REQ-015 On a grant: out_data <= in_data[g], out_sel <= g, out_valid <= 1, ptr <= g+1 (mod 4, 3 wraps to 0).
REQ-016 If load=1 and in_valid==0: out_valid <= 0; out_data, out_sel and ptr hold their values.
REQ-017 If load=0 (out_valid=1, out_ready=0): out_valid, out_data, out_sel and ptr SHALL hold; in_ready SHALL be 0.
REQ-018 Latency: a word granted in cycle N appears on out_data with out_valid=1 in cycle N+1.
REQ-019 Throughput: with out_ready held high and any in_valid bit set every cycle, one word SHALL be emitted per cycle (simultaneous drain and refill).
REQ-020 Fairness: with all four in_valid held high and out_ready held high, grants SHALL cycle 0,1,2,3,0,... after reset.
REQ-021 A source that drops in_valid is skipped with no idle cycle; ptr advances past the actual grant, not past the skipped indices.
REQ-022 Words SHALL never be duplicated or dropped: each in_valid&&in_ready handshake produces exactly one out_valid&&out_ready handshake, in grant order.

Reset
REQ-023 While rst=1 at a clock edge: out_valid <= 0, out_data <= 0, out_sel <= 0, ptr <= 0.
REQ-024 in_ready SHALL be 0 in every cycle in which rst=1.
REQ-025 Reset asserted while out_valid=1 SHALL discard the held word; no handshake is reported for it.
REQ-026 In the first cycle after rst deasserts, source 0 SHALL have highest priority.

Structure
REQ-027 A shared package SHALL hold the source count (4), the index width (2) and the default W.
REQ-028 Grant selection SHALL be a combinational sub-module rr_pick_4 (inputs: 4-bit request, 2-bit ptr; outputs: any, 2-bit index).
REQ-029 The payload path SHALL select in_data by the combinational grant index before the output register; the block contains no other storage.

Verification
REQ-030 Reset: assert rst 2 cycles with in_valid=4'hF -> in_ready=0 throughout, out_valid=0, out_data=0, out_sel=0.
REQ-031 Fairness: in_data0..3 = a,b,c,d, in_valid=4'hF, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3; out_data a,b,c,d,a,b,c,d; out_valid=1 every cycle.
REQ-032 Skip: after reset, grant src 0, then in_valid=4'b1010 -> next out_sel=1, then out_sel=3, then ptr wraps and out_sel=1.
REQ-033 Backpressure: out_valid=1 with out_sel=2, data 'hc; hold out_ready=0 for 3 cycles while in_valid=4'hF -> in_ready=0, out_data stays 'hc, out_sel stays 2; on out_ready=1 next out_sel=3.
REQ-034 Idle: in_valid=0, out_ready=1 for 2 cycles after a word with out_sel=1 -> out_valid=0, out_sel stays 1; then in_valid=4'b0001 -> out_sel=0, out_valid=1 next cycle.
REQ-035 Mid-operation reset: out_valid=1, out_ready=0, pulse rst one cycle -> out_valid=0 next cycle, and with in_valid=4'hF the next grant is source 0.
